// File: rtl/adder_chk_if.sv
// Bundle of stimulus, DUT-response and status signals exchanged between a
// vector source and the adder response checker.
interface adder_chk_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic             vec_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_fail_idx;
  logic [WIDTH-1:0] fail_A;
  logic [WIDTH-1:0] fail_B;
  logic             fail_Cin;
  logic [WIDTH-1:0] fail_S;
  logic             fail_Cout;

  modport master (
    output start, num_vectors, vec_valid, A, B, Cin, S, Cout,
    input  busy, done, pass, vec_count, err_count, first_fail_idx,
           fail_A, fail_B, fail_Cin, fail_S, fail_Cout
  );

  modport slave (
    input  start, num_vectors, vec_valid, A, B, Cin, S, Cout,
    output busy, done, pass, vec_count, err_count, first_fail_idx,
           fail_A, fail_B, fail_Cin, fail_S, fail_Cout
  );
endinterface

// File: rtl/adder_response_checker.sv
// Golden-model response checker for a WIDTH-bit adder: delays each accepted
// vector by LATENCY cycles, compares against the DUT S/Cout, keeps counts.
module adder_response_checker #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  adder_chk_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic [WIDTH-1:0] fs_q, fs_d;
  logic             fcin_q, fcin_d;
  logic             fcout_q, fcout_d;

  logic             accept_s;
  logic             clr_s;
  logic [WIDTH:0]   exp_s;
  logic             t_valid_s;
  logic [WIDTH-1:0] t_a_s;
  logic [WIDTH-1:0] t_b_s;
  logic             t_cin_s;
  logic [WIDTH:0]   t_exp_s;
  logic             cmp_s;
  logic             mismatch_s;
  logic [CNT_W-1:0] vec_inc_s;

  assign accept_s   = (state_q == RUN) && bus.vec_valid && (acc_q < num_q);
  assign clr_s      = (state_q != RUN) && bus.start;
  assign exp_s      = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
  assign cmp_s      = (state_q == RUN) && t_valid_s;
  assign mismatch_s = ({bus.Cout, bus.S} != t_exp_s);
  assign vec_inc_s  = vec_q + {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    if (LATENCY == 0) begin : g_comb
      assign t_valid_s = accept_s;
      assign t_a_s     = bus.A;
      assign t_b_s     = bus.B;
      assign t_cin_s   = bus.Cin;
      assign t_exp_s   = exp_s;
    end else begin : g_pipe
      logic             pv_q [LATENCY];
      logic [WIDTH-1:0] pa_q [LATENCY];
      logic [WIDTH-1:0] pb_q [LATENCY];
      logic             pc_q [LATENCY];
      logic [WIDTH:0]   pe_q [LATENCY];

      // Delay line aligning each vector and its golden sum with the DUT output.
      always_ff @(posedge clk) begin
        if (rst || clr_s) begin
          for (int i = 0; i < LATENCY; i++) begin
            pv_q[i] <= 1'b0;
            pa_q[i] <= {WIDTH{1'b0}};
            pb_q[i] <= {WIDTH{1'b0}};
            pc_q[i] <= 1'b0;
            pe_q[i] <= {(WIDTH+1){1'b0}};
          end
        end else begin
          pv_q[0] <= accept_s;
          pa_q[0] <= bus.A;
          pb_q[0] <= bus.B;
          pc_q[0] <= bus.Cin;
          pe_q[0] <= exp_s;
          for (int i = 1; i < LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pa_q[i] <= pa_q[i-1];
            pb_q[i] <= pb_q[i-1];
            pc_q[i] <= pc_q[i-1];
            pe_q[i] <= pe_q[i-1];
          end
        end
      end

      assign t_valid_s = pv_q[LATENCY-1];
      assign t_a_s     = pa_q[LATENCY-1];
      assign t_b_s     = pb_q[LATENCY-1];
      assign t_cin_s   = pc_q[LATENCY-1];
      assign t_exp_s   = pe_q[LATENCY-1];
    end
  endgenerate

  // Next-state, counter and first-failure capture logic.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    err_d   = err_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fs_d    = fs_q;
    fcin_d  = fcin_q;
    fcout_d = fcout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          num_d   = bus.num_vectors;
          acc_d   = {CNT_W{1'b0}};
          vec_d   = {CNT_W{1'b0}};
          err_d   = {CNT_W{1'b0}};
          idx_d   = {CNT_W{1'b0}};
          fa_d    = {WIDTH{1'b0}};
          fb_d    = {WIDTH{1'b0}};
          fs_d    = {WIDTH{1'b0}};
          fcin_d  = 1'b0;
          fcout_d = 1'b0;
          if (bus.num_vectors == {CNT_W{1'b0}}) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RUN;
            pass_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (accept_s) begin
          acc_d = acc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          acc_d = acc_q;
        end
        if (cmp_s) begin
          vec_d = vec_inc_s;
          if (mismatch_s) begin
            if (err_q != {CNT_W{1'b1}}) begin
              err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              err_d = err_q;
            end
            // Only the first mismatch of a run is captured.
            if (err_q == {CNT_W{1'b0}}) begin
              idx_d   = vec_q;
              fa_d    = t_a_s;
              fb_d    = t_b_s;
              fcin_d  = t_cin_s;
              fs_d    = bus.S;
              fcout_d = bus.Cout;
            end else begin
              idx_d = idx_q;
            end
          end else begin
            err_d = err_q;
          end
          if (vec_inc_s == num_q) begin
            state_d = DONE;
            pass_d  = (err_d == {CNT_W{1'b0}});
          end else begin
            state_d = RUN;
          end
        end else begin
          vec_d = vec_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= {CNT_W{1'b0}};
      acc_q   <= {CNT_W{1'b0}};
      vec_q   <= {CNT_W{1'b0}};
      err_q   <= {CNT_W{1'b0}};
      idx_q   <= {CNT_W{1'b0}};
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fa_q    <= {WIDTH{1'b0}};
      fb_q    <= {WIDTH{1'b0}};
      fs_q    <= {WIDTH{1'b0}};
      fcin_q  <= 1'b0;
      fcout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fs_q    <= fs_d;
      fcin_q  <= fcin_d;
      fcout_q <= fcout_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.vec_count      = vec_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = idx_q;
  assign bus.fail_A         = fa_q;
  assign bus.fail_B         = fb_q;
  assign bus.fail_Cin       = fcin_q;
  assign bus.fail_S         = fs_q;
  assign bus.fail_Cout      = fcout_q;

endmodule
